// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-bus arbiter and its rotate-priority picker.
// Optional watchdog is enabled by defining ARB_TIMEOUT_EN (see mem_bus_arbiter).
package mem_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_BUSY    = 2'd1;
  localparam logic [1:0] ARB_RELEASE = 2'd2;

  // Read data returned to a requester whose transaction was aborted by the watchdog.
  localparam logic [DATA_W-1:0] ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE    = ARB_IDLE,
    ST_BUSY    = ARB_BUSY,
    ST_RELEASE = ARB_RELEASE
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority selector: the first asserted request at or after
// ptr (wrapping modulo N) wins. N is limited to 2..4 so indices fit in two bits.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   ptr,
  output logic [1:0]   winner,
  output logic         any_valid
);

  logic [N-1:0] rot;
  logic [2:0]   sum;

  // Rotate so ptr lands on bit 0, then take the lowest set bit and map it back.
  always_comb begin
    rot       = N'({req, req} >> ptr);
    sum       = '0;
    winner    = '0;
    any_valid = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        sum = {1'b0, ptr} + 3'(j);
        if (sum >= 3'(N)) sum = sum - 3'(N);
        winner    = sum[1:0];
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory port between NREQ masters.
// Handshake: a requester holds valid and payload until it sees req_ready and drops
// valid on that same edge; the one-cycle RELEASE state gives it time to do so.
// Define ARB_TIMEOUT_EN to build the BUSY watchdog (TIMEOUT_CYCLES); otherwise
// timeout_err is tied low and a stalled memory holds the bus indefinitely.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_instr,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  input  logic [NREQ*STRB_W-1:0] req_wstrb,
  output logic [NREQ-1:0]        req_ready,
  output logic [DATA_W-1:0]      req_rdata,
  output logic                   mem_valid,
  output logic                   mem_instr,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic [STRB_W-1:0]      mem_wstrb,
  input  logic                   mem_ready,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic [1:0]             grant_id,
  output logic                   timeout_err
);

  arb_state_e        state_q, state_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_instr_q, mem_instr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;

  logic [1:0]        pick_idx;
  logic              pick_any;
  logic              sel_instr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;
  logic              tmo_hit;
  logic              txn_end;

  rr_pick #(.N(NREQ)) u_pick (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .winner    (pick_idx),
    .any_valid (pick_any)
  );

  // Only the picked requester's payload reaches the mem_* registers.
  always_comb begin
    sel_instr = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == 2'(i)) begin
        sel_instr = req_instr[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_wstrb = req_wstrb[i*STRB_W +: STRB_W];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Watchdog counts cycles spent in BUSY, restarting at every grant.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ST_IDLE && pick_any) tmo_cnt_d = '0;
    else if (state_q == ST_BUSY)        tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) tmo_cnt_q <= '0;
    else         tmo_cnt_q <= tmo_cnt_d;
  end

  // A memory completion on the last allowed cycle takes precedence over the abort.
  assign tmo_hit = (state_q == ST_BUSY) && !mem_ready && (tmo_cnt_q == TMO_LAST);
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  assign txn_end = (state_q == ST_BUSY) && (mem_ready || tmo_hit);

  // Next-state logic: arbitrate in IDLE, hold the bus in BUSY, one dead cycle in RELEASE.
  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_instr_d = mem_instr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          mem_valid_d = 1'b1;
          mem_instr_d = sel_instr;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          mem_wstrb_d = sel_wstrb;
          grant_d     = pick_idx;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (txn_end) begin
          mem_valid_d = 1'b0;
          rr_ptr_d    = (grant_q == 2'(NREQ - 1)) ? 2'd0 : grant_q + 2'd1;
          state_d     = ST_RELEASE;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State and memory-port registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      mem_valid_q <= 1'b0;
      mem_instr_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      grant_q     <= 2'd0;
      rr_ptr_q    <= 2'd0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_instr_q <= mem_instr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // Completion is steered combinationally to the current grant holder only.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = txn_end && mem_valid_q && (grant_q == 2'(i));
    end
  end

  assign req_rdata   = tmo_hit ? ARB_TIMEOUT_DATA : mem_rdata;
  assign timeout_err = tmo_hit;
  assign mem_valid   = mem_valid_q;
  assign mem_instr   = mem_instr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wstrb   = mem_wstrb_q;
  assign grant_id    = grant_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: three requester drivers, a latency-programmable memory
// model, and a negedge monitor that checks grants against a round-robin model and
// completions against per-requester expected queues.
module tb_mem_bus_arbiter;

  localparam int NREQ = 3;
  localparam int TMO  = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  wire  [NREQ-1:0]    req_valid;
  wire  [NREQ-1:0]    req_instr;
  wire  [NREQ*32-1:0] req_addr;
  wire  [NREQ*32-1:0] req_wdata;
  wire  [NREQ*4-1:0]  req_wstrb;
  logic [NREQ-1:0]    req_ready;
  logic [31:0]        req_rdata;
  logic               mem_valid, mem_instr;
  logic [31:0]        mem_addr, mem_wdata;
  logic [3:0]         mem_wstrb;
  logic               mem_ready = 1'b0;
  logic [31:0]        mem_rdata = '0;
  logic [1:0]         grant_id;
  logic               timeout_err;

  logic        d_valid[NREQ];
  logic        d_instr[NREQ];
  logic [31:0] d_addr[NREQ];
  logic [31:0] d_wdata[NREQ];
  logic [3:0]  d_wstrb[NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_valid[g]          = d_valid[g];
    assign req_instr[g]          = d_instr[g];
    assign req_addr[g*32 +: 32]  = d_addr[g];
    assign req_wdata[g*32 +: 32] = d_wdata[g];
    assign req_wstrb[g*4 +: 4]   = d_wstrb[g];
  end

  mem_bus_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_instr(req_instr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_ready(req_ready), .req_rdata(req_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant_id(grant_id), .timeout_err(timeout_err)
  );

  // ---------------- reference model ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Memory latency (BUSY cycles before mem_ready) is a function of the address.
  function automatic int mem_lat(input logic [31:0] a);
    return (int'(a[5:2]) + 2) % 16;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0000_0013;
    return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
  endfunction

  // Expected completion {timeout, rdata} for a transaction at address a.
  function automatic logic [32:0] expect_resp(input logic [31:0] a);
    logic [32:0] r;
    r = {1'b0, mem_word(a)};
`ifdef ARB_TIMEOUT_EN
    if (mem_lat(a) > TMO - 1) r = {1'b1, 32'hDEAD_BEEF};
`endif
    return r;
  endfunction

  logic [32:0] exp_q[NREQ][$];

  // ---------------- memory model ----------------
  int mem_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (!mem_valid) begin
      mem_cnt   = 0;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
    end else begin
      if (mem_cnt == mem_lat(mem_addr)) begin
        mem_ready = 1'b1;
        mem_rdata = mem_word(mem_addr);
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
      mem_cnt++;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic        snap_valid[NREQ];
  logic        snap_instr[NREQ];
  logic [31:0] snap_addr[NREQ];
  logic [31:0] snap_wdata[NREQ];
  logic [3:0]  snap_wstrb[NREQ];
  int          model_ptr = 0;
  int          model_grant = 0;
  logic        prev_mem_valid = 1'b0;
  int          cyc = 0;
  int          last_rise = -1;
  bit          spacing_on = 1'b0;
  int          mon_w;
  logic [32:0] mon_e;
  logic [31:0] g_addr = '0, g_wdata = '0;

  always @(negedge clk) begin
    cyc++;
    if (!resetn) begin
      model_ptr      = 0;
      model_grant    = 0;
      prev_mem_valid = 1'b0;
    end else begin
      if (mem_valid && !prev_mem_valid) begin
        mon_w = -1;
        for (int k = 0; k < NREQ; k++)
          if (mon_w < 0 && snap_valid[(model_ptr + k) % NREQ]) mon_w = (model_ptr + k) % NREQ;
        if (mon_w < 0) begin
          n_checks++;
          $display("FAIL grant: mem_valid rose with no request pending");
        end else begin
          check_eq("grant_id", 32'(grant_id), 32'(mon_w));
          check_eq("mem_instr", 32'(mem_instr), 32'(snap_instr[mon_w]));
          check_eq("mem_wstrb", 32'(mem_wstrb), 32'(snap_wstrb[mon_w]));
          g_addr  = snap_addr[mon_w];
          g_wdata = snap_wdata[mon_w];
          if (spacing_on && last_rise >= 0) check_eq("txn_spacing", 32'(cyc - last_rise), 32'd3);
          last_rise   = cyc;
          model_grant = mon_w;
          model_ptr   = (mon_w + 1) % NREQ;
        end
      end
      if (mem_valid) begin
        check_eq("mem_addr", mem_addr, g_addr);
        check_eq("mem_wdata", mem_wdata, g_wdata);
      end
      if (req_ready != '0) begin
        check_eq("ready_onehot", 32'(req_ready), 32'(1 << model_grant));
        if (exp_q[model_grant].size() == 0) begin
          n_checks++;
          $display("FAIL ready: unexpected completion to requester %0d", model_grant);
        end else begin
          mon_e = exp_q[model_grant].pop_front();
          check_eq("req_rdata", req_rdata, mon_e[31:0]);
          check_eq("timeout_err", 32'(timeout_err), 32'(mon_e[32]));
        end
      end else if (timeout_err) begin
        n_checks++;
        $display("FAIL timeout_err: got 1 without a completion, expected 0");
      end
      prev_mem_valid = mem_valid;
    end
    for (int i = 0; i < NREQ; i++) begin
      snap_valid[i] = d_valid[i];
      snap_instr[i] = d_instr[i];
      snap_addr[i]  = d_addr[i];
      snap_wdata[i] = d_wdata[i];
      snap_wstrb[i] = d_wstrb[i];
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after valid has been dropped.
  task automatic issue(input int id, input logic [31:0] a, input logic ins,
                       input logic [31:0] wd, input logic [3:0] ws);
    int  waited;
    bit  done;
    waited = 0;
    done   = 1'b0;
    d_addr[id]  = a;
    d_instr[id] = ins;
    d_wdata[id] = wd;
    d_wstrb[id] = ws;
    d_valid[id] = 1'b1;
    exp_q[id].push_back(expect_resp(a));
    while (!done) begin
      @(negedge clk);
      waited++;
      if (req_ready[id]) done = 1'b1;
      else if (waited > 400) begin
        n_checks++;
        $display("FAIL wait_ready: requester %0d got no req_ready within 400 cycles", id);
        done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    d_valid[id] = 1'b0;
    d_addr[id]  = $urandom;
    d_wdata[id] = $urandom;
    d_wstrb[id] = 4'($urandom_range(0, 15));
    d_instr[id] = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_stream(input int id, input int n);
    logic [31:0] a, wd;
    logic [3:0]  ws;
    logic        ins;
    for (int t = 0; t < n; t++) begin
      idle_cycles($urandom_range(0, 3));
      a   = $urandom & 32'hFFFF_FFFC;
      wd  = $urandom;
      ws  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      ins = (ws == 4'h0) ? 1'($urandom_range(0, 1)) : 1'b0;
      issue(id, a, ins, wd, ws);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  // ---------------- main sequence ----------------
  int guard;

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      d_valid[i] = 1'b0;
      d_instr[i] = 1'b0;
      d_addr[i]  = '0;
      d_wdata[i] = '0;
      d_wstrb[i] = '0;
    end
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_mem_valid", 32'(mem_valid), 32'd0);
    check_eq("rst_mem_instr", 32'(mem_instr), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check_eq("rst_grant_id", 32'(grant_id), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_timeout_err", 32'(timeout_err), 32'd0);
    #2 resetn = 1'b1;
    idle_cycles(2);

    // Single CPU fetch: visible on the memory port one edge after the request.
    fork
      issue(0, 32'h0000_0100, 1'b1, 32'h0, 4'h0);
      begin
        @(posedge clk);
        #2;
        check_eq("fetch_mem_valid", 32'(mem_valid), 32'd1);
        check_eq("fetch_mem_addr", mem_addr, 32'h0000_0100);
        check_eq("fetch_mem_instr", 32'(mem_instr), 32'd1);
        check_eq("fetch_grant_id", 32'(grant_id), 32'd0);
      end
    join
    idle_cycles(2);

    // Contention with zero-wait memory (address bits [5:2] = 14 gives latency 0).
    spacing_on = 1'b1;
    last_rise  = -1;
    fork
      for (int t = 0; t < 4; t++) issue(0, 32'h0000_1038 + 32'(t << 8), 1'b0, $urandom, 4'h0);
      for (int t = 0; t < 4; t++) issue(1, 32'h0000_2038 + 32'(t << 8), 1'b0, $urandom, 4'hF);
    join
    spacing_on = 1'b0;
    idle_cycles(2);

    // Write routing from requester 1.
    fork
      issue(1, 32'h0000_2000, 1'b0, 32'hCAFE_F00D, 4'hF);
      begin
        @(posedge clk);
        #2;
        check_eq("write_mem_wdata", mem_wdata, 32'hCAFE_F00D);
        check_eq("write_mem_wstrb", 32'(mem_wstrb), 32'hF);
      end
    join
    idle_cycles(2);

    // Memory latency exactly at the watchdog limit, then well beyond it while
    // another requester waits for the next grant.
    issue(2, 32'h0000_3014, 1'b0, 32'h0, 4'h0);
    fork
      issue(2, 32'h0000_3034, 1'b0, 32'h0, 4'h0);
      begin
        idle_cycles(1);
        issue(0, 32'h0000_4038, 1'b1, 32'h0, 4'h0);
      end
    join
    idle_cycles(2);

    // Randomized traffic from all requesters.
    fork
      rand_stream(0, 12);
      rand_stream(1, 12);
      rand_stream(2, 12);
    join
    idle_cycles(3);

    // Reset in the middle of a long transaction: no completion may be issued.
    d_addr[2]  = 32'h0000_5034;
    d_instr[2] = 1'b0;
    d_wdata[2] = 32'h0;
    d_wstrb[2] = 4'h0;
    d_valid[2] = 1'b1;
    guard = 0;
    while (!mem_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_eq("midrst_busy_seen", 32'(mem_valid), 32'd1);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check_eq("midrst_mem_valid", 32'(mem_valid), 32'd0);
    check_eq("midrst_req_ready", 32'(req_ready), 32'd0);
    d_valid[2] = 1'b0;
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("midrst_grant_id", 32'(grant_id), 32'd0);
    check_eq("midrst_mem_valid_after", 32'(mem_valid), 32'd0);
    @(posedge clk);
    #1;

    // After reset the pointer is back at 0: requester 0 wins over requester 1.
    fork
      issue(1, 32'h0000_6038, 1'b0, 32'h1234_5678, 4'h3);
      issue(0, 32'h0000_7038, 1'b1, 32'h0, 4'h0);
    join
    idle_cycles(4);

    for (int i = 0; i < NREQ; i++)
      check_eq($sformatf("queue_empty_%0d", i), 32'(exp_q[i].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Round-robin arbiter that shares one valid/ready memory port between NREQ bus masters: the RISC-V CPU core, the PIM accelerator's load/store engine, and the debug loader. It sits between the masters and the unified instruction/data memory. It grants exactly one transaction at a time, registers the winner's request onto the memory port, and steers the completion back to the winner.

## Interface
Parameters:
- NREQ, 2: number of requesters; legal range 2..4. Index 0 is the CPU.
- TIMEOUT_CYCLES, 256: watchdog limit in cycles. Used only when ARB_TIMEOUT_EN is defined.

Ports (clock and reset first):
- clk  in  1  clock.
- resetn  in  1  reset; asynchronous, active-low.
- req_valid  in  NREQ  per-requester request strobe.
- req_instr  in  NREQ  instruction-fetch flag.
- req_addr  in  NREQ*32  address; requester i occupies bits [32i+31:32i].
- req_wdata  in  NREQ*32  write data, same packing as req_addr.
- req_wstrb  in  NREQ*4  byte strobes; 0 means read.
- req_ready  out  NREQ  completion strobe to each requester.
- req_rdata  out  32  read data, shared by all requesters.
- mem_valid  out  1  request to memory.
- mem_instr  out  1  fetch flag to memory.
- mem_addr  out  32  address to memory.
- mem_wdata  out  32  write data to memory.
- mem_wstrb  out  4  byte strobes to memory.
- mem_ready  in  1  memory completion.
- mem_rdata  in  32  memory read data.
- grant_id  out  2  index of the current or last grant.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

## Operation
- Requester contract:
  - A requester holds valid and its payload stable until it sees req_ready.
  - It drops valid on the clock edge where req_ready=1.
- State machine: IDLE, BUSY, RELEASE.
- IDLE
  - Scan req_valid starting at rr_ptr, wrapping modulo NREQ. The first asserted index wins.
  - On a win: latch the winner's payload into the mem_* registers, set mem_valid=1, set grant_id to the winner, and go to BUSY.
  - If no requester is valid: stay in IDLE with mem_valid=0.
- BUSY
  - The mem_* outputs are held constant.
  - When mem_ready=1: clear mem_valid, set rr_ptr to (grant_id+1) mod NREQ, and go to RELEASE.
- RELEASE
  - Lasts one cycle with mem_valid=0.
  - All req_valid inputs are ignored, so the finishing requester has time to drop valid.
  - Then go to IDLE.
- Completion path (combinational):
  - req_ready[i] = mem_valid & mem_ready & (grant_id==i) while in BUSY.
  - req_rdata = mem_rdata, passed straight through.
- Fairness:
  - With all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0.
  - No requester waits more than NREQ-1 transactions.
- A req_valid that drops while not granted is legal and is simply not seen.
- Requester inputs other than the granted one are never forwarded to memory.

## Timing
- Reset values:
  - mem_valid=0, mem_instr=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
  - grant_id=0, rr_ptr=0, timeout_err=0.
  - req_ready=0 (follows from mem_valid=0).
  - State=IDLE.
- Arbitration latency: req_valid sampled at edge N gives mem_valid=1 after edge N.
- Minimum per-transaction cost: 1 arbitration edge, then the memory latency, then 1 RELEASE cycle.
- Back-to-back throughput with zero-wait memory: one transaction per 3 cycles.
- A grant made in IDLE at the same edge another requester asserts valid: the late requester waits for the next IDLE.
- Reset asserted mid-transaction:
  - Outputs clear immediately (asynchronous reset).
  - No req_ready is issued for the aborted transaction.
  - Memory sees mem_valid drop. The memory must tolerate an abandoned request.

## Configuration
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter restarts at 0 on entry to BUSY and increments every BUSY cycle.
  - When it reaches TIMEOUT_CYCLES-1 without mem_ready, the arbiter aborts the transaction.
  - On abort: clear mem_valid, pulse req_ready[grant_id] for one cycle with req_rdata forced to 32'hDEAD_BEEF, pulse timeout_err, advance rr_ptr, and go to RELEASE.
  - If mem_ready and the limit coincide, mem_ready wins, the completion is normal, and there is no error.
- Undefined:
  - No counter is built and timeout_err is tied to 0.
  - A stalled memory holds the bus forever.

## Structure
- Shared package mem_bus_pkg:
  - State encoding localparams ARB_IDLE, ARB_BUSY, ARB_RELEASE.
  - Constant ARB_TIMEOUT_DATA=32'hDEAD_BEEF.
  - Width constants ADDR_W=32, DATA_W=32, STRB_W=4.
- One sub-module: rr_pick.
  - Combinational rotate-priority selector.
  - Inputs: req vector and rr_ptr.
  - Outputs: winner index and any_valid.
  - Reused by the planned PIM bank scheduler.

## Test plan
- Single CPU fetch: req_valid=01, addr 0x100, memory ready 2 cycles later. Required: mem_addr=0x100 and mem_instr=1 one edge after the request; req_ready[0] pulses once with rdata 0x00000013; grant_id=0.
- Contention: both valid every cycle, zero-wait memory. Required: grant sequence 0,1,0,1 with 3 cycles per transaction; req_ready is never asserted for the non-granted requester.
- Write routing: requester 1 writes 0xCAFEF00D to 0x2000 with wstrb 1111 while requester 0 is idle. Required: mem_wdata=0xCAFEF00D, mem_wstrb=1111.
- Reset mid-BUSY: resetn low while mem_valid=1. Required: mem_valid=0 immediately, no req_ready pulse, grant_id=0 after release.
- With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, memory never ready. Required: after 8 BUSY cycles req_ready pulses with rdata 0xDEADBEEF, timeout_err=1 for one cycle, and the next requester is granted.
- With ARB_TIMEOUT_EN, mem_ready arrives exactly on cycle 8. Required: normal rdata and timeout_err=0.
